// File: rtl/mem_arbiter.sv
// Two-port (CPU/DMA) round-robin arbiter in front of a fixed-latency single-port memory.
// Latency: request seen in IDLE at T -> strobes T+1..T+MEM_LATENCY -> ack at T+MEM_LATENCY+1.
// Backpressure: one transaction in flight; requesters hold req/operands until ack, no abort on early drop.
module mem_arbiter #(
    parameter int WORD_SIZE   = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 wr0,
    input  logic                 wr1,
    input  logic [WORD_SIZE-1:0] addr0,
    input  logic [WORD_SIZE-1:0] addr1,
    input  logic [WORD_SIZE-1:0] wdata0,
    input  logic [WORD_SIZE-1:0] wdata1,
    output logic                 ack0,
    output logic                 ack1,
    output logic [WORD_SIZE-1:0] rdata,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 busy,
    output logic                 owner,
    output logic [WORD_SIZE-1:0] num_access
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter reload: the strobe stays up while the counter walks LAT_M1 down to 0.
    localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

    state_t               r_state;
    logic [3:0]           r_cnt;
    logic                 r_owner;
    logic                 r_wr;
    logic                 r_last;      // port granted most recently; 1 after reset so port 0 wins first tie
    logic [WORD_SIZE-1:0] r_addr;
    logic [WORD_SIZE-1:0] r_wdata;
    logic [WORD_SIZE-1:0] r_rdata;
    logic [WORD_SIZE-1:0] r_num;
    logic                 r_readM;
    logic                 r_writeM;
    logic                 r_ack0;
    logic                 r_ack1;
    logic                 r_busy;

    logic                 w_any;
    logic                 w_win;
    logic                 w_win_wr;
    logic [WORD_SIZE-1:0] w_win_addr;
    logic [WORD_SIZE-1:0] w_win_wdata;

    // Round-robin pick: a lone requester wins, a tie goes to the port not granted last.
    always_comb begin
        w_any = req0 | req1;
        if (req0 && req1) begin
            w_win = ~r_last;
        end else begin
            w_win = req1;
        end
        w_win_wr    = w_win ? wr1    : wr0;
        w_win_addr  = w_win ? addr1  : addr0;
        w_win_wdata = w_win ? wdata1 : wdata0;
    end

    // Single FSM: grant and latch operands in IDLE, strobe memory in BUSY, acknowledge in RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_owner  <= 1'b0;
            r_wr     <= 1'b0;
            r_last   <= 1'b1;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_num    <= '0;
            r_readM  <= 1'b0;
            r_writeM <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner  <= w_win;
                        r_wr     <= w_win_wr;
                        r_addr   <= w_win_addr;
                        r_wdata  <= w_win_wdata;
                        r_cnt    <= LAT_M1;
                        r_readM  <= ~w_win_wr;
                        r_writeM <= w_win_wr;
                        r_busy   <= 1'b1;
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_readM  <= 1'b0;
                        r_writeM <= 1'b0;
                        if (!r_wr) begin
                            r_rdata <= mem_rdata;
                        end
                        r_ack0   <= ~r_owner;
                        r_ack1   <= r_owner;
                        r_state  <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    // Ack is visible this cycle; completion count and fairness pointer update on exit.
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_num   <= r_num + 1'b1;
                    r_last  <= r_owner;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_readM  <= 1'b0;
                    r_writeM <= 1'b0;
                    r_ack0   <= 1'b0;
                    r_ack1   <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign ack0       = r_ack0;
    assign ack1       = r_ack1;
    assign rdata      = r_rdata;
    assign readM      = r_readM;
    assign writeM     = r_writeM;
    assign address    = r_addr;
    assign mem_wdata  = r_wdata;
    assign busy       = r_busy;
    assign owner      = r_owner;
    assign num_access = r_num;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: main instance at defaults, plus an 8-bit, latency-1 instance
// used to reach the completion-counter wrap quickly.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req0, req1, wr0, wr1;
    logic [15:0] addr0, addr1, wdata0, wdata1, mem_rdata;
    logic        ack0, ack1, readM, writeM, busy, owner;
    logic [15:0] rdata, address, mem_wdata, num_access;

    logic        w_req;
    logic        w_ack0, w_ack1, w_readM, w_writeM, w_busy, w_owner;
    logic [7:0]  w_rdata, w_address, w_mem_wdata, w_num;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(2)) u_dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata),
        .readM(readM), .writeM(writeM), .address(address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner), .num_access(num_access)
    );

    mem_arbiter #(.WORD_SIZE(8), .MEM_LATENCY(1)) u_wrap (
        .clk(clk), .reset(reset),
        .req0(w_req), .req1(1'b0), .wr0(1'b0), .wr1(1'b0),
        .addr0(8'h05), .addr1(8'h00), .wdata0(8'h00), .wdata1(8'h00),
        .ack0(w_ack0), .ack1(w_ack1), .rdata(w_rdata),
        .readM(w_readM), .writeM(w_writeM), .address(w_address), .mem_wdata(w_mem_wdata),
        .mem_rdata(8'hA5), .busy(w_busy), .owner(w_owner), .num_access(w_num)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; mem_rdata = 0;
        w_req = 0;
        tick();
        tick();
        n_tests++;
        if ({readM, writeM, ack0, ack1, busy, owner} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got rd/wr/a0/a1/busy/own=%b required 000000",
                     {readM, writeM, ack0, ack1, busy, owner});
        end
        n_tests++;
        if ({address, mem_wdata, rdata, num_access} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data got addr=%h wdata=%h rdata=%h num=%h required all 0",
                     address, mem_wdata, rdata, num_access);
        end
        n_tests++;
        if (w_num !== 8'h00) begin
            n_fail++; $display("FAIL reset_wrap_num got %h required 00", w_num);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        req0 = 1; wr0 = 0; addr0 = 16'h0010; mem_rdata = 16'h1234;
        tick();  // T+1
        n_tests++;
        if ({readM, writeM, busy, owner} !== 4'b1010 || address !== 16'h0010) begin
            n_fail++;
            $display("FAIL read_t1 got rd/wr/busy/own=%b addr=%h required 1010 addr=0010",
                     {readM, writeM, busy, owner}, address);
        end
        tick();  // T+2
        n_tests++;
        if (readM !== 1'b1 || ack0 !== 1'b0) begin
            n_fail++; $display("FAIL read_t2 got readM=%b ack0=%b required 1 0", readM, ack0);
        end
        tick();  // T+3
        n_tests++;
        if ({readM, ack0, ack1} !== 3'b010 || rdata !== 16'h1234) begin
            n_fail++;
            $display("FAIL read_ack got rd/a0/a1=%b rdata=%h required 010 rdata=1234",
                     {readM, ack0, ack1}, rdata);
        end
        req0 = 0;
        tick();  // T+4
        n_tests++;
        if (ack0 !== 1'b0 || busy !== 1'b0 || num_access !== 16'd1) begin
            n_fail++;
            $display("FAIL read_done got ack0=%b busy=%b num=%0d required 0 0 1", ack0, busy, num_access);
        end
    endtask

    task automatic test_single_write();
        req1 = 1; wr1 = 1; addr1 = 16'h0020; wdata1 = 16'hBEEF; mem_rdata = 16'h5555;
        tick();  // T+1
        n_tests++;
        if ({readM, writeM, owner} !== 3'b011 || mem_wdata !== 16'hBEEF || address !== 16'h0020) begin
            n_fail++;
            $display("FAIL write_t1 got rd/wr/own=%b wdata=%h addr=%h required 011 BEEF 0020",
                     {readM, writeM, owner}, mem_wdata, address);
        end
        tick();  // T+2
        n_tests++;
        if ({readM, writeM} !== 2'b01) begin
            n_fail++; $display("FAIL write_t2 got rd/wr=%b required 01", {readM, writeM});
        end
        tick();  // T+3
        n_tests++;
        if ({writeM, ack0, ack1} !== 3'b001 || rdata !== 16'h1234) begin
            n_fail++;
            $display("FAIL write_ack got wr/a0/a1=%b rdata=%h required 001 rdata=1234",
                     {writeM, ack0, ack1}, rdata);
        end
        req1 = 0; wr1 = 0;
        tick();
        n_tests++;
        if (num_access !== 16'd2) begin
            n_fail++; $display("FAIL write_num got %0d required 2", num_access);
        end
    endtask

    task automatic test_operand_change();
        req0 = 1; wr0 = 0; addr0 = 16'h0010; mem_rdata = 16'h7777;
        tick();  // T+1: grant happened, now disturb operands
        addr0 = 16'h0030; wr0 = 1; wdata0 = 16'hDEAD;
        tick();  // T+2
        n_tests++;
        if (address !== 16'h0010 || {readM, writeM} !== 2'b10 || mem_wdata === 16'hDEAD) begin
            n_fail++;
            $display("FAIL opchg_t2 got addr=%h rd/wr=%b wdata=%h required addr=0010 rd/wr=10 wdata!=DEAD",
                     address, {readM, writeM}, mem_wdata);
        end
        tick();  // T+3
        n_tests++;
        if (ack0 !== 1'b1 || address !== 16'h0010 || rdata !== 16'h7777) begin
            n_fail++;
            $display("FAIL opchg_ack got ack0=%b addr=%h rdata=%h required 1 0010 7777", ack0, address, rdata);
        end
        req0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
        tick();
    endtask

    task automatic test_tie();
        logic e0, e1;
        reset = 1; tick(); reset = 0;
        req0 = 1; req1 = 1; wr0 = 0; wr1 = 0; addr0 = 16'h0100; addr1 = 16'h0200;
        for (int i = 1; i <= 11; i++) begin
            tick();
            e0 = (i == 3 || i == 11);
            e1 = (i == 7);
            n_tests++;
            if (ack0 !== e0 || ack1 !== e1) begin
                n_fail++;
                $display("FAIL tie_ack cyc%0d got a0/a1=%b%b required %b%b", i, ack0, ack1, e0, e1);
            end
            if (i == 1 || i == 9) begin
                n_tests++;
                if (address !== 16'h0100 || owner !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tie_grant0 cyc%0d got addr=%h own=%b required 0100 0", i, address, owner);
                end
            end
            if (i == 5) begin
                n_tests++;
                if (address !== 16'h0200 || owner !== 1'b1) begin
                    n_fail++;
                    $display("FAIL tie_grant1 got addr=%h own=%b required 0200 1", address, owner);
                end
            end
            if (i == 11) begin
                req0 = 0; req1 = 0;
            end
        end
        tick();
        n_tests++;
        if (num_access !== 16'd3 || busy !== 1'b0) begin
            n_fail++; $display("FAIL tie_num got num=%0d busy=%b required 3 0", num_access, busy);
        end
    endtask

    task automatic test_reset_mid_busy();
        req0 = 1; wr0 = 0; addr0 = 16'h0040;
        tick();  // T+1, first strobe cycle
        n_tests++;
        if (readM !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_strobe got readM=%b required 1", readM);
        end
        reset = 1;
        tick();  // T+2
        n_tests++;
        if ({readM, ack0, ack1, busy} !== 4'b0 || num_access !== 16'd0) begin
            n_fail++;
            $display("FAIL rstmid_abort got rd/a0/a1/busy=%b num=%0d required 0000 0",
                     {readM, ack0, ack1, busy}, num_access);
        end
        reset = 0;
        req1 = 1; wr1 = 0; addr1 = 16'h0050;
        tick();  // T+3
        n_tests++;
        if ({ack0, ack1} !== 2'b00 || owner !== 1'b0 || address !== 16'h0040 || readM !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_tie got a0/a1=%b own=%b addr=%h readM=%b required 00 0 0040 1",
                     {ack0, ack1}, owner, address, readM);
        end
        tick();
        tick();  // T+5
        n_tests++;
        if ({ack0, ack1} !== 2'b10) begin
            n_fail++; $display("FAIL rstmid_ack got a0/a1=%b required 10", {ack0, ack1});
        end
        req0 = 0; req1 = 0;
        tick();
        n_tests++;
        if (num_access !== 16'd1) begin
            n_fail++; $display("FAIL rstmid_num got %0d required 1", num_access);
        end
    endtask

    task automatic test_back_to_back();
        req0 = 1; wr0 = 0; addr0 = 16'h0060;
        tick(); tick(); tick();  // T+3 ack
        n_tests++;
        if (ack0 !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ack1 got ack0=%b required 1", ack0);
        end
        tick();  // T+4: idle gap, request still held
        n_tests++;
        if ({readM, busy, ack0} !== 3'b000) begin
            n_fail++; $display("FAIL b2b_gap got rd/busy/a0=%b required 000", {readM, busy, ack0});
        end
        tick();  // T+5: second transaction strobing
        n_tests++;
        if (readM !== 1'b1 || owner !== 1'b0) begin
            n_fail++; $display("FAIL b2b_regrant got readM=%b own=%b required 1 0", readM, owner);
        end
        tick(); tick();  // T+7
        n_tests++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_ack2 got a0/a1=%b%b required 10", ack0, ack1);
        end
        req0 = 0;
        tick();
        n_tests++;
        if (num_access !== 16'd3) begin
            n_fail++; $display("FAIL b2b_num got %0d required 3", num_access);
        end
    endtask

    task automatic test_counter_wrap();
        int acks = 0;
        w_req = 1;
        for (int i = 0; i < 2000 && acks < 255; i++) begin
            tick();
            if (w_ack0) begin
                acks++;
                if (acks == 255) w_req = 0;
            end
        end
        w_req = 0;
        n_tests++;
        if (acks !== 255) begin
            n_fail++; $display("FAIL wrap_budget got %0d acks required 255", acks);
        end
        tick();
        n_tests++;
        if (w_num !== 8'hFF) begin
            n_fail++; $display("FAIL wrap_pre got %h required FF", w_num);
        end
        w_req = 1;
        acks = 0;
        for (int i = 0; i < 10 && acks == 0; i++) begin
            tick();
            if (w_ack0) acks = 1;
        end
        w_req = 0;
        n_tests++;
        if (acks !== 1) begin
            n_fail++; $display("FAIL wrap_last_ack got %0d acks required 1", acks);
        end
        tick();
        n_tests++;
        if (w_num !== 8'h00) begin
            n_fail++; $display("FAIL wrap_post got %h required 00", w_num);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_operand_change();
        test_tie();
        test_reset_mid_busy();
        test_back_to_back();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, data/address width.
REQ-002 SHALL have parameter MEM_LATENCY, default 2, number of cycles the memory strobe is held per access (legal range 1..15).
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports req0/req1  input  1  access request from port 0 (CPU) and port 1 (DMA).
REQ-006 SHALL have ports wr0/wr1  input  1  1 = write, 0 = read, for the matching port.
REQ-007 SHALL have ports addr0/addr1  input  WORD_SIZE  word address per port.
REQ-008 SHALL have ports wdata0/wdata1  input  WORD_SIZE  write data per port.
REQ-009 SHALL have ports ack0/ack1  output  1  one-cycle completion pulse per port.
REQ-010 SHALL have port rdata  output  WORD_SIZE  read data, valid in the ack cycle.
REQ-011 SHALL have ports readM/writeM  output  1  memory read/write strobes.
REQ-012 SHALL have port address  output  WORD_SIZE  memory address.
REQ-013 SHALL have port mem_wdata  output  WORD_SIZE  data driven to memory.
REQ-014 SHALL have port mem_rdata  input  WORD_SIZE  data returned by memory.
REQ-015 SHALL have ports busy  output  1 and owner  output  1  (transaction in flight; granted port).
REQ-016 SHALL have port num_access  output  WORD_SIZE  count of completed transactions.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-018 SHALL sample requests only in IDLE; if any reqN=1, it SHALL latch owner, wr, addr, wdata of the winner and go to BUSY with the latency counter loaded with MEM_LATENCY-1.
REQ-019 SHALL arbitrate round-robin: a single requester always wins; on a tie, the port not granted last wins; after reset, port 0 wins the first tie.
REQ-020 In BUSY, SHALL assert exactly one of readM/writeM (per latched wr) for exactly MEM_LATENCY consecutive cycles, with address and mem_wdata stable at latched values.
REQ-021 On the last BUSY cycle (counter = 0), SHALL register mem_rdata into rdata (reads only; writes leave rdata unchanged) and go to RESP.
REQ-022 In RESP, SHALL pulse ack of the owner for one cycle, increment num_access (mod 2^WORD_SIZE, wrap 0xFFFF->0x0000), update last-granted pointer, and return to IDLE.
REQ-023 Latency: request seen in IDLE at cycle T -> strobes T+1..T+MEM_LATENCY -> ack at T+MEM_LATENCY+1; one IDLE cycle separates back-to-back transactions.
REQ-024 Requesters SHALL hold reqN and operands until ackN; deassertion mid-transaction SHALL NOT abort it, and ack SHALL still pulse.
REQ-025 Changes on addrN/wdataN/wrN after grant SHALL NOT affect the transaction in flight.
REQ-026 readM and writeM SHALL never be asserted simultaneously and SHALL be 0 in IDLE and RESP; ack0 and ack1 SHALL never be asserted simultaneously.
REQ-027 busy SHALL be 1 in BUSY and RESP, 0 in IDLE; owner SHALL hold the last granted port.
REQ-028 A request held through its own ack cycle SHALL be treated as a new request in the following IDLE cycle.

Reset
REQ-029 With reset=1 at a rising edge, SHALL enter IDLE; readM, writeM, ack0, ack1, busy, owner=0; address, mem_wdata, rdata, num_access = 0; last-granted pointer = port 1.
REQ-030 Reset during BUSY or RESP SHALL abort the transaction without issuing ack, and strobes SHALL be 0 in the cycle following that edge.

Verification
REQ-031 Single read: MEM_LATENCY=2, req0=1, wr0=0, addr0=0x0010, mem_rdata=0x1234 -> readM high 2 cycles with address=0x0010, ack0 at T+3, rdata=0x1234, num_access=1.
REQ-032 Single write: req1=1, wr1=1, addr1=0x0020, wdata1=0xBEEF -> writeM high 2 cycles, mem_wdata=0xBEEF, ack1 at T+3, rdata unchanged.
REQ-033 Tie after reset: req0=req1=1 held -> grant order port0, port1, port0; acks 4 cycles apart (MEM_LATENCY=2), never simultaneous.
REQ-034 Operand change: addr0 changes 0x0010->0x0030 one cycle after grant -> address stays 0x0010 for the whole transaction.
REQ-035 Reset mid-BUSY: assert reset in first strobe cycle -> no ack, readM=0 next cycle, num_access=0, next tie won by port 0.
REQ-036 Counter wrap: force 65536 transactions (or preload via long run) -> num_access wraps 0xFFFF->0x0000 on the next ack.
